updn_sweep_ctrl: RTL

Sequencing controller for the 32-bit up/down counter datapath. On a start request it loads a low bound, drives the counter up to a high bound and back down, and repeats for a programmed number of sweeps. It owns the `sense` direction control and the count value, and reports progress with `busy`, `done` and `cfg_err`. It sits between a configuration/host side (start, bounds, sweep count) and any consumer of a triangular count sequence.

---
 rtl/updn_sweep_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/updn_sweep_ctrl.sv
// Triangle-sweep sequencer: loads lo, counts up to hi and back down to lo,
// repeating for a latched number of sweeps, with abort and config checking.
module updn_sweep_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic               sense,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    UP   = 2'd2,
    DN   = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     data_reg, data_next;
  logic                 sense_reg, sense_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 cfg_err_reg, cfg_err_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [SWEEP_W-1:0]   sw_reg, sw_next;

  logic [WIDTH-1:0]     data_inc;
  logic [WIDTH-1:0]     data_dec;
  logic                 cfg_ok;

  assign data_inc = data_reg + WIDTH'(1);
  assign data_dec = data_reg - WIDTH'(1);
  // lo < hi guarantees the up/down walk never wraps, even at the top of range
  assign cfg_ok   = (lo < hi) && (sweeps != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      sense_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
      lo_reg      <= '0;
      hi_reg      <= '0;
      sw_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      sense_reg   <= sense_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      cfg_err_reg <= cfg_err_next;
      lo_reg      <= lo_next;
      hi_reg      <= hi_next;
      sw_reg      <= sw_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    sense_next   = sense_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    cfg_err_next = 1'b0;
    lo_next      = lo_reg;
    hi_next      = hi_reg;
    sw_next      = sw_reg;

    case (state_reg)
      IDLE: begin
        // abort while idle swallows any start in the same cycle
        if (start && !abort) begin
          if (cfg_ok) begin
            lo_next    = lo;
            hi_next    = hi;
            sw_next    = sweeps;
            busy_next  = 1'b1;
            state_next = LOAD;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      LOAD: begin
        data_next  = lo_reg;
        sense_next = 1'b1;
        state_next = UP;
      end
      UP: begin
        data_next = data_inc;
        if (data_inc == hi_reg) begin
          sense_next = 1'b0;
          state_next = DN;
        end
      end
      DN: begin
        data_next = data_dec;
        if (data_dec == lo_reg) begin
          sw_next    = sw_reg - SWEEP_W'(1);
          sense_next = 1'b1;
          if (sw_reg == SWEEP_W'(1)) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = UP;
          end
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // Abort overrides any in-flight step; the count freezes where it was
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      data_next  = data_reg;
      sense_next = 1'b1;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      sw_next    = sw_reg;
    end
  end

  assign sense    = sense_reg;
  assign data_out = data_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign cfg_err  = cfg_err_reg;

endmodule
